// File: rtl/memory_pipe_be.sv
// memory_pipe_be: single-port memory with byte enables, zero-init sweep, range check and read pipeline.
// Define MEM_PARITY_EN to add per-byte even parity with par_inj / par_err.
module memory_pipe_be #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int MEM_DEPTH  = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    WE,
  input  logic                    RE,
  input  logic [DATA_WIDTH/8-1:0] BE,
`ifdef MEM_PARITY_EN
  input  logic                    par_inj,
  output logic                    par_err,
`endif
  input  logic [ADDR_WIDTH-1:0]   Address,
  input  logic [DATA_WIDTH-1:0]   Data_in,
  output logic [DATA_WIDTH-1:0]   Data_out,
  output logic                    valid_out,
  output logic                    ready,
  output logic                    addr_err
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(MEM_DEPTH - 1);
  typedef enum logic {INIT, RUN} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [IW-1:0] idx;
  logic in_range, sweep, wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [RD_LATENCY-1:0] pv_q, pe_q;
  logic [DATA_WIDTH-1:0] pd_q [RD_LATENCY];
  logic [DATA_WIDTH-1:0] dout_q;
  logic valid_q, err_q, wr_err_q;
  assign idx      = Address[IW-1:0];
  assign in_range = {1'b0, Address} < (ADDR_WIDTH + 1)'(MEM_DEPTH);
  assign sweep    = state_q == INIT;
  assign wr_acc   = state_q == RUN && WE;
  assign rd_acc   = state_q == RUN && RE && !WE;
  assign rd_word  = in_range ? mem[idx] : '0;
  assign ready     = state_q == RUN;
  assign Data_out  = dout_q;
  assign valid_out = valid_q;
  assign addr_err  = err_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (sweep) begin
      cnt_d   = cnt_q + ADDR_WIDTH'(1);
      state_d = cnt_q == LAST ? RUN : INIT;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // No reset on the array: the INIT sweep is what clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (sweep) mem[cnt_q[IW-1:0]] <= '0;
      else if (wr_acc && in_range)
        for (int b = 0; b < NB; b++)
          if (BE[b]) mem[idx][8*b +: 8] <= Data_in[8*b +: 8];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      pv_q     <= '0;
      pe_q     <= '0;
      for (int k = 0; k < RD_LATENCY; k++) pd_q[k] <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      pv_q[0] <= rd_acc;
      pe_q[0] <= rd_acc && !in_range;
      pd_q[0] <= rd_word;
      for (int k = 1; k < RD_LATENCY; k++) begin
        pv_q[k] <= pv_q[k-1];
        pe_q[k] <= pe_q[k-1];
        pd_q[k] <= pd_q[k-1];
      end
      valid_q  <= pv_q[RD_LATENCY-1];
      dout_q   <= pv_q[RD_LATENCY-1] ? pd_q[RD_LATENCY-1] : dout_q;
      err_q    <= (pv_q[RD_LATENCY-1] && pe_q[RD_LATENCY-1]) || wr_err_q;
      wr_err_q <= wr_acc && !in_range;
    end
  end
`ifdef MEM_PARITY_EN
  logic [NB-1:0] par [MEM_DEPTH];
  logic [RD_LATENCY-1:0] pp_q;
  logic rd_perr, perr_q;
  assign par_err = perr_q;
  always_comb begin
    rd_perr = 1'b0;
    for (int b = 0; b < NB; b++) rd_perr = rd_perr | ^{par[idx][b], mem[idx][8*b +: 8]};
    rd_perr = rd_perr && in_range;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      if (sweep) par[cnt_q[IW-1:0]] <= '0;
      else if (wr_acc && in_range)
        for (int b = 0; b < NB; b++)
          if (BE[b]) par[idx][b] <= ^Data_in[8*b +: 8] ^ par_inj;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      pp_q   <= '0;
      perr_q <= 1'b0;
    end else begin
      pp_q[0] <= rd_acc && rd_perr;
      for (int k = 1; k < RD_LATENCY; k++) pp_q[k] <= pp_q[k-1];
      perr_q <= pv_q[RD_LATENCY-1] && pp_q[RD_LATENCY-1];
    end
  end
`endif
endmodule

// File: tb/tb_memory_pipe_be.sv
// tb_memory_pipe_be: random and directed stimulus against a queue-based model of memory_pipe_be.
module tb_memory_pipe_be;
  localparam int DW = 32, AW = 4, D = 12, L = 3, NB = 4;
  logic clk = 0, rst = 0, WE = 0, RE = 0;
  logic [NB-1:0] BE = '0;
  logic [AW-1:0] Address = '0;
  logic [DW-1:0] Data_in = '0, Data_out;
  logic valid_out, ready, addr_err;
  logic pinj = 0;
`ifdef MEM_PARITY_EN
  logic par_err;
`endif
  always #5 clk = ~clk;
  memory_pipe_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(D), .RD_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .WE(WE), .RE(RE), .BE(BE),
`ifdef MEM_PARITY_EN
    .par_inj(pinj), .par_err(par_err),
`endif
    .Address(Address), .Data_in(Data_in), .Data_out(Data_out),
    .valid_out(valid_out), .ready(ready), .addr_err(addr_err));
  int vectors = 0, miscompares = 0;
  task automatic chk(string n, logic [DW-1:0] act, logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endtask
  typedef struct {int due; logic [DW-1:0] d; bit e; bit p;} rd_t;
  rd_t q[$], r;
  logic [DW-1:0] m [16];
  logic [NB-1:0] pb [16];
  int cyc = 0, sc = 0;
  bit armed = 0, rdy_m = 0, wpend = 0, e_v = 0, e_err = 0, e_perr = 0;
  logic [DW-1:0] e_dout = '0;
  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      armed = 1; rdy_m = 0; sc = 0; q.delete(); wpend = 0;
      e_dout = '0; e_v = 0; e_err = 0; e_perr = 0;
    end else if (armed) begin
      e_v = 0; e_err = wpend; e_perr = 0; wpend = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        r = q.pop_front();
        e_v = 1; e_dout = r.d; e_err = e_err | r.e; e_perr = r.p;
      end
      if (!rdy_m) begin
        m[sc] = '0; pb[sc] = '0; sc++; rdy_m = sc == D;
      end else if (WE) begin
        if (Address < D) begin
          for (int b = 0; b < NB; b++)
            if (BE[b]) begin m[Address][8*b +: 8] = Data_in[8*b +: 8]; pb[Address][b] = pinj; end
        end else wpend = 1;
      end else if (RE)
        q.push_back('{due: cyc + L, d: (Address < D) ? m[Address] : 32'h0,
                      e: Address >= D, p: (Address < D) && (|pb[Address])});
    end
    #1;
    if (armed) begin
      chk("ready", {31'b0, ready}, {31'b0, rdy_m});
      chk("valid_out", {31'b0, valid_out}, {31'b0, e_v});
      chk("addr_err", {31'b0, addr_err}, {31'b0, e_err});
      chk("Data_out", Data_out, e_dout);
`ifdef MEM_PARITY_EN
      chk("par_err", {31'b0, par_err}, {31'b0, e_perr});
`endif
    end
  end
  task automatic idle();
    @(negedge clk); WE = 0; RE = 0; pinj = 0;
  endtask
  task automatic wr(input logic [AW-1:0] a, input logic [NB-1:0] be, input logic [DW-1:0] d);
    @(negedge clk); WE = 1; RE = 0; Address = a; BE = be; Data_in = d;
  endtask
  task automatic read_lit(input logic [AW-1:0] a, input logic [DW-1:0] exp, input logic ee);
    @(negedge clk); WE = 0; RE = 1; Address = a; pinj = 0;
    @(negedge clk); RE = 0;
    repeat (L) @(posedge clk);
    #2;
    chk("lit_valid", {31'b0, valid_out}, 32'd1);
    chk("lit_data", Data_out, exp);
    chk("lit_err", {31'b0, addr_err}, {31'b0, ee});
  endtask
  task automatic wait_ready(output int n, output int nv);
    n = 0; nv = 0;
    do begin @(posedge clk); #2; n++; nv += int'(valid_out); end while (!ready && n < 100);
  endtask
  int n, nv;
  initial begin
    repeat (3) @(negedge clk);
    rst = 1;
    wait_ready(n, nv);
    chk("ready_latency", n, 12);
    for (int a = 0; a < D; a++) begin
      @(negedge clk); WE = 0; RE = 1; Address = AW'(a);
    end
    idle();
    read_lit(4, 32'h0, 0);
    wr(5, 4'hF, 32'hDEADBEEF);
    read_lit(5, 32'hDEADBEEF, 0);
    wr(2, 4'hF, 32'h11223344);
    wr(2, 4'b0101, 32'hAABBCCDD);
    read_lit(2, 32'h11BB33DD, 0);
    chk("model_be", m[2], 32'h11BB33DD);
    @(negedge clk); WE = 1; RE = 1; Address = 7; BE = 4'hF; Data_in = 32'h5A5A5A5A;
    idle();
    repeat (L + 1) @(posedge clk);
    #2 chk("we_re_novalid", {31'b0, valid_out}, 32'd0);
    read_lit(7, 32'h5A5A5A5A, 0);
    wr(13, 4'hF, 32'hFFFFFFFF);
    @(negedge clk); WE = 0;
    @(posedge clk);
    #2 chk("wr_oor_err", {31'b0, addr_err}, 32'd1);
    read_lit(13, 32'h0, 1);
    read_lit(5, 32'hDEADBEEF, 0);
`ifdef MEM_PARITY_EN
    @(negedge clk); WE = 1; RE = 0; Address = 3; BE = 4'hF; Data_in = 32'h01020304; pinj = 1;
    read_lit(3, 32'h01020304, 0);
    chk("par_inj", {31'b0, par_err}, 32'd1);
`endif
    @(negedge clk); rst = 0;
    @(negedge clk); rst = 1;
    repeat (6) @(posedge clk);
    @(negedge clk); rst = 0;
    @(negedge clk); rst = 1;
    wait_ready(n, nv);
    chk("sweep_restart", n, 12);
    chk("sweep_novalid", nv, 0);
    @(negedge clk); WE = 0; RE = 1; Address = 5;
    @(negedge clk); RE = 0; rst = 0;
    @(negedge clk); rst = 1;
    wait_ready(n, nv);
    chk("midread_ready", n, 12);
    chk("midread_novalid", nv, 0);
    read_lit(5, 32'h0, 0);
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rst = ($urandom % 250) != 0;
      WE = ($urandom % 3) == 0;
      RE = $urandom % 2 == 1;
      Address = AW'($urandom % 16);
      BE = NB'($urandom);
      Data_in = $urandom;
      pinj = ($urandom % 8) == 0;
    end
    @(negedge clk); rst = 1; WE = 0; RE = 0; pinj = 0;
    repeat (20) @(posedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
